obj_cmd_bank: RTL

Parametrised successor of the address/command object array. It receives framed serial commands directly from the serializer output (data plus busy/frame strobe) and checks each frame for length, parity and address. Valid commands are applied to a bank of OBJ_NUM status bits, addressed from 1, with 0 as broadcast. Each processed frame produces either an acknowledge pulse or an error code, and rejected frames are counted.

---
 rtl/obj_cmd_pkg.sv | 31 +++
 rtl/obj_cmd_rx.sv | 108 ++++++++++
 rtl/obj_cmd_bank.sv | 98 +++++++++
 3 files changed

// File: rtl/obj_cmd_pkg.sv
// Shared types for the framed serial command bank: op codes, error causes,
// receiver states and the frame length helper.
package obj_cmd_pkg;

    typedef enum logic [1:0] {
        CLR = 2'b00,
        SET = 2'b01,
        TGL = 2'b10,
        NOP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_PAR  = 2'b01,
        ERR_LEN  = 2'b10,
        ERR_ADDR = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SHIFT   = 2'b01,
        DISCARD = 2'b10,
        EXEC    = 2'b11
    } state_t;

    // Frame is {addr, op[1:0], par}.
    function automatic int unsigned frame_len(input int unsigned addr_w);
        return addr_w + 3;
    endfunction

endpackage

// File: rtl/obj_cmd_rx.sv
// Frame receiver: shifts serial bits in MSB first, counts them, detects
// overrun and accumulates parity; raises frame_done for one cycle in EXEC.
module obj_cmd_rx
    import obj_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_data,
    input  logic              frame,
    output logic [ADDR_W-1:0] addr,
    output op_t               op,
    output logic              frame_done,
    output logic              len_err,
    output logic              par_err
);

    localparam int unsigned FRAME_LEN = frame_len(ADDR_W);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(FRAME_LEN);

    state_t                 state, state_nxt;
    logic [FRAME_LEN-1:0]   shreg;
    logic [CNT_W-1:0]       cnt;
    logic                   overrun;
    logic                   par;
    logic                   start;
    logic                   shift_en;
    logic                   ovr_set;
    logic                   done_nxt;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        ovr_set   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (frame) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (frame) begin
                    if (cnt < LEN_CNT) begin
                        shift_en = 1'b1;
                    end else begin
                        ovr_set   = 1'b1;
                        state_nxt = DISCARD;
                    end
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            DISCARD: begin
                if (!frame) begin
                    done_nxt  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            overrun    <= 1'b0;
            par        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            if (start) begin
                shreg   <= {shreg[FRAME_LEN-2:0], ser_data};
                cnt     <= CNT_W'(1);
                par     <= ser_data;
                overrun <= 1'b0;
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_LEN-2:0], ser_data};
                cnt   <= cnt + 1'b1;
                par   <= par ^ ser_data;
            end else if (state == EXEC) begin
                shreg   <= '0;
                cnt     <= '0;
                par     <= 1'b0;
                overrun <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    // Flags are stable from frame end through EXEC, when frame_done is high.
    assign len_err = overrun || (cnt != LEN_CNT);
    assign par_err = par;
    assign addr    = shreg[FRAME_LEN-1 -: ADDR_W];
    assign op      = op_t'(shreg[2:1]);

endmodule

// File: rtl/obj_cmd_bank.sv
// Command bank: validates received frames and applies CLR/SET/TGL/NOP to a
// bank of status bits (address 0 broadcasts), with ack/error pulses and counter.
module obj_cmd_bank
    import obj_cmd_pkg::*;
#(
    parameter int unsigned         OBJ_NUM     = 18,
    parameter int unsigned         ADDR_W      = 5,
    parameter int unsigned         ERR_CNT_W   = 8,
    parameter logic [OBJ_NUM-1:0]  STATUS_INIT = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ser_data_i,
    input  logic                 frame_i,
    output logic [OBJ_NUM-1:0]   status_o,
    output logic                 cmd_ack_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [ADDR_W-1:0]  rx_addr;
    op_t                rx_op;
    logic               frame_done;
    logic               len_err;
    logic               par_err;
    logic               addr_err;
    err_t               err_sel;
    logic [OBJ_NUM-1:0] status_nxt;

    obj_cmd_rx #(
        .ADDR_W (ADDR_W)
    ) u_rx (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .ser_data   (ser_data_i),
        .frame      (frame_i),
        .addr       (rx_addr),
        .op         (rx_op),
        .frame_done (frame_done),
        .len_err    (len_err),
        .par_err    (par_err)
    );

    assign addr_err = rx_addr > ADDR_W'(OBJ_NUM);

    always_comb begin
        err_sel = ERR_NONE;
        if (len_err) begin
            err_sel = ERR_LEN;
        end else if (par_err) begin
            err_sel = ERR_PAR;
        end else if (addr_err) begin
            err_sel = ERR_ADDR;
        end
    end

    // Object k lives at address k+1; address 0 hits every object.
    always_comb begin
        status_nxt = status_o;
        for (int unsigned k = 0; k < OBJ_NUM; k++) begin
            if ((rx_addr == '0) || (rx_addr == ADDR_W'(k + 1))) begin
                case (rx_op)
                    CLR:     status_nxt[k] = 1'b0;
                    SET:     status_nxt[k] = 1'b1;
                    TGL:     status_nxt[k] = ~status_o[k];
                    default: status_nxt[k] = status_o[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            status_o   <= STATUS_INIT;
            cmd_ack_o  <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            cmd_ack_o <= 1'b0;
            err_o     <= 1'b0;
            if (frame_done) begin
                if (err_sel == ERR_NONE) begin
                    status_o  <= status_nxt;
                    cmd_ack_o <= 1'b1;
                end else begin
                    err_o      <= 1'b1;
                    err_code_o <= err_sel;
                    if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + 1'b1;
                    end
                end
            end
        end
    end

endmodule
